netwalk_tcam_prog_ctrl: RTL

//  Control-plane sequencer for a bank of netwalk_tcam_unit instances. Accepts program/delete commands
//  via valid/ready, stalls the lookup pipeline until in-flight lookups drain, drives the TCAM program
//  bus and one-hot unit select, and tracks per-entry occupancy.

---
 rtl/netwalk_tcam_prog_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/netwalk_tcam_prog_ctrl.sv
// Program/delete sequencer for a bank of TCAM units: drains lookups,
// drives the shared program bus and tracks per-entry occupancy.
module netwalk_tcam_prog_ctrl #(
   parameter int DPL_MATCH_FIELD_WIDTH = 356,
   parameter int TCAM_ADDR_WIDTH       = 6,
   parameter int NUM_TCAM_UNITS        = 4,
   parameter int UNIT_SEL_WIDTH        = 2,
   parameter int LOOKUP_LAT            = 2,
   parameter int WRITE_CYCLES          = 2
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     cmd_valid,
   output logic                                     cmd_ready,
   input  logic                                     cmd_op,
   input  logic [UNIT_SEL_WIDTH+TCAM_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DPL_MATCH_FIELD_WIDTH-1:0]         cmd_data,
   input  logic [DPL_MATCH_FIELD_WIDTH-1:0]         cmd_mask,
   output logic                                     lookup_stall,
   output logic [DPL_MATCH_FIELD_WIDTH-1:0]         tcam_program_data,
   output logic [DPL_MATCH_FIELD_WIDTH-1:0]         tcam_program_mask,
   output logic [TCAM_ADDR_WIDTH-1:0]               tcam_program_addr,
   output logic [NUM_TCAM_UNITS-1:0]                tcam_unit_sel,
   output logic                                     tcam_program_enable,
   output logic                                     tcam_delete_enable,
   output logic                                     rsp_valid,
   output logic                                     rsp_error,
   output logic [UNIT_SEL_WIDTH+TCAM_ADDR_WIDTH:0]  entry_count
);

   localparam int AW = UNIT_SEL_WIDTH + TCAM_ADDR_WIDTH;
   localparam int DW = DPL_MATCH_FIELD_WIDTH;
   localparam int CW = 8;
   localparam logic [UNIT_SEL_WIDTH:0] NU = (UNIT_SEL_WIDTH+1)'(NUM_TCAM_UNITS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_WRITE,
      S_RESP
   } state_t;

   state_t                      r_state;
   logic [CW-1:0]               r_cnt;
   logic                        r_op;
   logic [AW-1:0]               r_addr;
   logic [DW-1:0]               r_data;
   logic [DW-1:0]               r_mask;
   logic [(2**AW)-1:0]          r_valid;
   logic [AW:0]                 r_count;
   logic                        r_ready;
   logic                        r_stall;
   logic [DW-1:0]               r_pdata;
   logic [DW-1:0]               r_pmask;
   logic [TCAM_ADDR_WIDTH-1:0]  r_paddr;
   logic [NUM_TCAM_UNITS-1:0]   r_usel;
   logic                        r_pen;
   logic                        r_den;
   logic                        r_rsp;
   logic                        r_err;

   logic                        w_unit_bad;
   logic                        w_err;
   logic [NUM_TCAM_UNITS-1:0]   w_onehot;

   always_comb begin
      w_unit_bad = ({1'b0, cmd_addr[AW-1:TCAM_ADDR_WIDTH]} >= NU);
      w_err      = w_unit_bad | (cmd_op & ~r_valid[cmd_addr]);
      w_onehot   = '0;
      for (int i = 0; i < NUM_TCAM_UNITS; i++) begin
         w_onehot[i] = (r_addr[AW-1:TCAM_ADDR_WIDTH] == UNIT_SEL_WIDTH'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_mask  <= '0;
         r_valid <= '0;
         r_count <= '0;
         r_ready <= 1'b1;
         r_stall <= 1'b0;
         r_pdata <= '0;
         r_pmask <= '0;
         r_paddr <= '0;
         r_usel  <= '0;
         r_pen   <= 1'b0;
         r_den   <= 1'b0;
         r_rsp   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_op    <= cmd_op;
                  r_addr  <= cmd_addr;
                  r_data  <= cmd_data;
                  r_mask  <= cmd_mask;
                  r_ready <= 1'b0;
                  r_cnt   <= '0;
                  if (w_err) begin
                     r_state <= S_RESP;
                     r_rsp   <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= S_DRAIN;
                     r_stall <= 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (r_cnt == CW'(LOOKUP_LAT - 1)) begin
                  r_state <= S_WRITE;
                  r_cnt   <= '0;
                  r_pen   <= 1'b1;
                  r_den   <= r_op;
                  r_usel  <= w_onehot;
                  r_paddr <= r_addr[TCAM_ADDR_WIDTH-1:0];
                  r_pdata <= r_op ? '0 : r_data;
                  r_pmask <= r_op ? '0 : r_mask;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_WRITE: begin
               if (r_cnt == CW'(WRITE_CYCLES - 1)) begin
                  r_state <= S_RESP;
                  r_cnt   <= '0;
                  r_stall <= 1'b0;
                  r_pen   <= 1'b0;
                  r_den   <= 1'b0;
                  r_usel  <= '0;
                  r_rsp   <= 1'b1;
                  r_err   <= 1'b0;
                  // Occupancy commits together with the response pulse.
                  if (r_op) begin
                     r_valid[r_addr] <= 1'b0;
                     r_count         <= r_count - (AW+1)'(1);
                  end else begin
                     r_valid[r_addr] <= 1'b1;
                     if (!r_valid[r_addr]) r_count <= r_count + (AW+1)'(1);
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
               r_rsp   <= 1'b0;
               r_err   <= 1'b0;
               r_ready <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready           = r_ready;
   assign lookup_stall        = r_stall;
   assign tcam_program_data   = r_pdata;
   assign tcam_program_mask   = r_pmask;
   assign tcam_program_addr   = r_paddr;
   assign tcam_unit_sel       = r_usel;
   assign tcam_program_enable = r_pen;
   assign tcam_delete_enable  = r_den;
   assign rsp_valid           = r_rsp;
   assign rsp_error           = r_err;
   assign entry_count         = r_count;

endmodule
